// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master for the single-clock SPI slave. Frames 10-bit
// command words MSB first under SS_n. For rd-data commands it also collects
// a byte from MISO.
// Optional build macro SPI_MASTER_SEQCHK_EN: enables rd-addr/rd-data
// sequencing checks (seq_err). When it is undefined, seq_err is tied to 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready=1, SS_n=1
// SETUP | 2 cycles with MOSI=word[9] so the slave can leave its idle state
// SHIFT | 10 cycles, MOSI=word[9..0]
// TAIL  | 1 cycle, MOSI=0, SS_n still low so the slave flags rx_valid
// WAIT  | rd-data only, RD_GAP cycles of slave+RAM latency
// RECV  | rd-data only, 8 MISO samples, MSB first
// GAP   | IDLE_GAP cycles with SS_n=1 before returning to IDLE
// ERR   | rejected rd-data (no rd-addr pending), one cycle, no frame
module spi_master_ctrl #(
  parameter int RD_GAP   = 2,  // must be >= 1
  parameter int IDLE_GAP = 1   // must be >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [9:0] cmd_word,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       seq_err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int WW = (RD_GAP   > 1) ? $clog2(RD_GAP)   : 1;
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(RD_GAP - 1);
  localparam logic [GW-1:0] GAP_INIT  = GW'(IDLE_GAP - 1);

  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_TAIL,
    S_WAIT,
    S_RECV,
    S_GAP,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    word_q, word_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          seq_err_q, seq_err_d;
  logic          ss_n_q, ss_n_d;
  logic          mosi_q, mosi_d;
  logic          addr_pending_q, addr_pending_d;
  logic          reject_rd;
  logic          warn_rd_addr;

  // Sequencing check decisions for the command offered in IDLE.
`ifdef SPI_MASTER_SEQCHK_EN
  always_comb begin
    reject_rd    = (cmd_word[9:8] == CMD_RD_DATA) && !addr_pending_q;
    warn_rd_addr = (cmd_word[9:8] == CMD_RD_ADDR) &&  addr_pending_q;
  end
`else
  always_comb begin
    reject_rd    = 1'b0;
    warn_rd_addr = 1'b0;
  end
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    bit_cnt_d      = bit_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    rx_d           = rx_q;
    rsp_data_d     = rsp_data_q;
    rsp_valid_d    = 1'b0;
    seq_err_d      = 1'b0;
    ss_n_d         = 1'b1;
    mosi_d         = 1'b0;
    addr_pending_d = addr_pending_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          word_d = cmd_word;
          if (reject_rd) begin
            state_d   = S_ERR;
            seq_err_d = 1'b1;
          end else begin
            state_d   = S_SETUP;
            bit_cnt_d = 4'd1;
            ss_n_d    = 1'b0;
            mosi_d    = cmd_word[9];
            seq_err_d = warn_rd_addr;
          end
        end
      end

      S_SETUP: begin
        ss_n_d = 1'b0;
        mosi_d = word_q[9];
        if (bit_cnt_q == 4'd0) begin
          state_d   = S_SHIFT;
          bit_cnt_d = 4'd9;
        end else begin
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end

      // MOSI currently carries word_q[bit_cnt_q]; queue up the next bit.
      S_SHIFT: begin
        ss_n_d = 1'b0;
        if (bit_cnt_q == 4'd0) begin
          state_d = S_TAIL;
        end else begin
          bit_cnt_d = bit_cnt_q - 4'd1;
          mosi_d    = word_q[bit_cnt_q - 4'd1];
        end
      end

      S_TAIL: begin
        if (word_q[9:8] == CMD_RD_DATA) begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_INIT;
          ss_n_d     = 1'b0;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_INIT;
          if (word_q[9:8] == CMD_RD_ADDR) begin
            addr_pending_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        ss_n_d = 1'b0;
        if (wait_cnt_q == '0) begin
          state_d   = S_RECV;
          bit_cnt_d = 4'd7;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      S_RECV: begin
        rx_d = {rx_q[6:0], MISO};
        if (bit_cnt_q == 4'd0) begin
          state_d        = S_GAP;
          gap_cnt_d      = GAP_INIT;
          rsp_data_d     = {rx_q[6:0], MISO};
          rsp_valid_d    = 1'b1;
          addr_pending_d = 1'b0;
        end else begin
          ss_n_d    = 1'b0;
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      word_q         <= '0;
      bit_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      rx_q           <= '0;
      rsp_data_q     <= '0;
      rsp_valid_q    <= 1'b0;
      seq_err_q      <= 1'b0;
      ss_n_q         <= 1'b1;
      mosi_q         <= 1'b0;
      addr_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_q         <= word_d;
      bit_cnt_q      <= bit_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      rx_q           <= rx_d;
      rsp_data_q     <= rsp_data_d;
      rsp_valid_q    <= rsp_valid_d;
      seq_err_q      <= seq_err_d;
      ss_n_q         <= ss_n_d;
      mosi_q         <= mosi_d;
      addr_pending_q <= addr_pending_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign seq_err   = seq_err_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl with a bench-side
// slave+RAM that decodes MOSI and answers rd-data frames on MISO, and a
// frame-level model of the expected master outputs checked every cycle.
module tb_spi_master_ctrl;

  localparam int RD_GAP   = 2;
  localparam int IDLE_GAP = 1;
  localparam int RECV0    = 13 + RD_GAP;   // frame index of first MISO bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_word = '0;
  logic       cmd_ready, rsp_valid, busy, seq_err, SS_n, MOSI;
  logic [7:0] rsp_data;
  logic       MISO = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_master_ctrl #(.RD_GAP(RD_GAP), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .seq_err(seq_err), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- slave + RAM seen through the pins ----------------
  logic [7:0]  s_ram [0:255];
  logic [7:0]  s_addr = '0;
  logic [7:0]  s_rd = '0;
  logic [11:0] s_bits = '0;
  logic [9:0]  last_rx = '0;
  int          s_cnt = 0;

  always @(negedge clk) begin
    int idx;
    if (SS_n === 1'b0) begin
      idx = s_cnt;
      s_cnt++;
      if (idx < 12) s_bits = {s_bits[10:0], MOSI};
      if (idx == 12) begin
        last_rx = s_bits[9:0];
        case (s_bits[9:8])
          2'b00: s_addr = s_bits[7:0];
          2'b01: s_ram[s_addr] = s_bits[7:0];
          2'b10: s_addr = s_bits[7:0];
          default: s_rd = s_ram[s_addr];
        endcase
      end
      if (idx >= RECV0 && idx < RECV0 + 8) MISO = s_rd[RECV0 + 7 - idx];
      else MISO = 1'b0;
    end else begin
      s_cnt = 0;
      MISO  = 1'b0;
    end
  end

  // ---------------- pin-level monitors ----------------
  int lo_run = 0, hi_run = 0, last_low = 0, frm_cnt = 0, rv_cnt = 0, se_cnt = 0;
  bit in_low = 0, seen_low = 0;
  int hi_q[$];

  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (!in_low) begin
        if (seen_low) hi_q.push_back(hi_run);
        in_low = 1; lo_run = 0; frm_cnt++;
      end
      lo_run++;
    end else begin
      if (in_low) begin
        last_low = lo_run; in_low = 0; seen_low = 1; hi_run = 0;
      end
      hi_run++;
    end
    if (rsp_valid === 1'b1) rv_cnt++;
    if (seq_err === 1'b1) se_cnt++;
  end

  // ---------------- frame-level model ----------------
  // m_pos: cycles since acceptance (0 = first cycle after the accepting edge),
  // -1 when idle. m_len = SS_n-low cycles, m_tot = m_len + GAP cycles.
  logic [7:0] m_ram [0:255];
  logic [7:0] m_addr = '0;
  logic [7:0] m_rsp = '0;
  logic [9:0] m_word = '0;
  bit         m_on = 0, m_pend = 0, m_err = 0;
  int         m_pos = -1, m_len = 0, m_tot = 0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_ram[i] = '0;
      s_ram[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; m_pos = -1; m_rsp = '0; m_pend = 0;
    end else if (m_on) begin
      if (m_pos >= 0) begin
        m_pos++;
        if (m_len > 0 && m_pos == m_len) begin
          case (m_word[9:8])
            2'b00: m_addr = m_word[7:0];
            2'b01: m_ram[m_addr] = m_word[7:0];
            2'b10: begin m_addr = m_word[7:0]; m_pend = 1; end
            default: begin m_rsp = m_ram[m_addr]; m_pend = 0; end
          endcase
        end
        if (m_pos == m_tot) m_pos = -1;
      end else if (cmd_valid) begin
        m_word = cmd_word;
        m_pos  = 0;
        m_err  = 0;
        m_len  = (cmd_word[9:8] == 2'b11) ? 13 + RD_GAP + 8 : 13;
        m_tot  = m_len + IDLE_GAP;
`ifdef SPI_MASTER_SEQCHK_EN
        if (cmd_word[9:8] == 2'b11 && !m_pend) begin
          m_err = 1; m_len = 0; m_tot = 1;
        end
        if (cmd_word[9:8] == 2'b10 && m_pend) m_err = 1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic e_ss, e_mosi, e_busy, e_rv, e_se;
    int p;
    if (m_on) begin
      p = m_pos;
      e_ss = 1; e_mosi = 0; e_busy = 0; e_rv = 0; e_se = 0;
      if (p >= 0) begin
        e_busy = 1;
        if (p < m_len) begin
          e_ss = 0;
          if (p < 2) e_mosi = m_word[9];
          else if (p < 12) e_mosi = m_word[11 - p];
        end
        e_rv = (m_word[9:8] == 2'b11) && (m_len > 0) && (p == m_len);
        e_se = m_err && (p == 0);
      end
      chk("ss_n", SS_n, e_ss);
      chk("mosi", MOSI, e_mosi);
      chk("busy", busy, e_busy);
      chk("cmd_ready", cmd_ready, !e_busy);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_data", rsp_data, m_rsp);
      chk("seq_err", seq_err, e_se);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [9:0] w, input bit hold);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_word  = w;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n >= 100, 0);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n >= 300, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int rv0, se0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_rsp_data", rsp_data, 8'h00);

    // rd-data straight after reset: rejected with seq_err, or framed as-is
    send(10'h300, 0);
    wait_idle();
`ifdef SPI_MASTER_SEQCHK_EN
    chk("seq_frames", frm_cnt, 0);
    chk("seq_err_cnt", se_cnt, 1);
`else
    chk("noseq_frames", frm_cnt, 1);
    chk("noseq_err_cnt", se_cnt, 0);
`endif

    // write address 0x A5
    send(10'h0A5, 0);
    wait_idle();
    chk("wa_rx", last_rx, 10'h0A5);
    chk("wa_bits", s_bits, 12'h0A5);
    chk("wa_low", last_low, 13);

    // write data 3C to address A5
    send(10'h13C, 0);
    wait_idle();
    chk("wd_rx", last_rx, 10'h13C);
    chk("wd_ram", s_ram[8'hA5], 8'h3C);

    // read back
    send(10'h2A5, 0);
    wait_idle();
    send(10'h300, 0);
    wait_idle();
    chk("rd_data", rsp_data, 8'h3C);
    chk("rd_model", m_rsp, 8'h3C);
    chk("rd_low", last_low, 23);

    // reset for 2 cycles in the middle of the RECV phase
    send(10'h2A5, 0);
    wait_idle();
    rv0 = rv_cnt;
    send(10'h300, 0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort_ss_n", SS_n, 1);
    chk("abort_mosi", MOSI, 0);
    chk("abort_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", rv_cnt, rv0);
    chk("abort_hold", rsp_data, 8'h00);

    // two rd-addr frames in a row, then rd-data
    se0 = se_cnt;
    send(10'h2A5, 0);
    wait_idle();
    send(10'h2A5, 0);
    wait_idle();
    send(10'h300, 0);
    wait_idle();
`ifdef SPI_MASTER_SEQCHK_EN
    chk("dbl_rd_addr_err", se_cnt - se0, 1);
`else
    chk("dbl_rd_addr_err", se_cnt - se0, 0);
`endif
    chk("dbl_rd_data", rsp_data, 8'h3C);

    // back-to-back with cmd_valid held across four words
    hi_q.delete();
    rv0 = rv_cnt;
    send(10'h011, 1);
    send(10'h1AB, 1);
    send(10'h211, 1);
    send(10'h300, 0);
    wait_idle();
    chk("b2b_gaps", hi_q.size(), 4);
    // between frames: IDLE_GAP cycles of GAP plus the accepting IDLE cycle
    for (int i = 1; i < hi_q.size(); i++) chk("b2b_gap_len", hi_q[i], IDLE_GAP + 1);
    chk("b2b_rsp_cnt", rv_cnt - rv0, 1);
    chk("b2b_rsp", rsp_data, 8'hAB);
    chk("b2b_ram", s_ram[8'h11], 8'hAB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0t exp=done", $time);
    $fatal(1, "timeout");
  end

endmodule
